// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: dual-write register file with write-to-read bypass and per-register pending-write scoreboard
module regfile_scoreboard #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 4,
  parameter int NREGS      = 15,
  parameter int CNT_W      = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic [ADDR_W-1:0] claimE,
  input  logic [ADDR_W-1:0] claimM,
  input  logic              claim_v,
  output logic              stall,
  output logic              pend_any,
  output logic              sb_err
);
  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt  [NREGS];
  logic [NREGS-1:0]  inc, dec, busy, full;
  logic              ve, vm;

  function automatic logic impl(input logic [ADDR_W-1:0] id);
    return int'(id) < NREGS;
  endfunction

  assign ve = impl(dstE);
  assign vm = impl(dstM);

  function automatic logic fwd(input logic [ADDR_W-1:0] s);
    return BYPASS != 0 && ((ve && s == dstE) || (vm && s == dstM));
  endfunction

  // During reset the outputs show only reset contents, so forwarding is suppressed.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] s);
    return !impl(s) ? '0 :
           (BYPASS != 0 && !rst && vm && s == dstM) ? valM :
           (BYPASS != 0 && !rst && ve && s == dstE) ? valE : regs[s];
  endfunction

  function automatic logic haz(input logic [ADDR_W-1:0] s);
    return impl(s) && cnt[s] != '0 && !fwd(s);
  endfunction

  assign valA     = rd(srcA);
  assign valB     = rd(srcB);
  assign stall    = haz(srcA) || haz(srcB);
  assign pend_any = |busy;

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_sb
      assign inc[g]  = claim_v && !stall && (claimE == ADDR_W'(g) || claimM == ADDR_W'(g));
      assign dec[g]  = dstE == ADDR_W'(g) || dstM == ADDR_W'(g);
      assign busy[g] = cnt[g] != '0;
      assign full[g] = &cnt[g];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (dstM == ADDR_W'(i)) regs[i] <= valM;
        else if (dstE == ADDR_W'(i)) regs[i] <= valE;
        if (inc[i] && !dec[i] && !full[i]) cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec[i] && !inc[i] && busy[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
      if (|(inc & ~dec & full)) sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors with queued expectations checked by a separate monitor
module tb_regfile_scoreboard;
  localparam logic [3:0] N = 4'hF;
  logic        clk = 0, rst = 1, chk = 0;
  logic [3:0]  srcA = 0, srcB = 0, dstE = N, dstM = N, claimE = N, claimM = N;
  logic [63:0] valA, valB, valE = 0, valM = 0;
  logic        claim_v = 0, stall, pend_any, sb_err;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    string       nm;
    logic [63:0] a, b;
    logic        st, pd, er;
  } exp_t;
  exp_t q[$];

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .claimE(claimE), .claimM(claimM), .claim_v(claim_v),
    .stall(stall), .pend_any(pend_any), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL queue_underrun: no expectation queued");
      end else begin
        e = q.pop_front();
        if (valA !== e.a || valB !== e.b || stall !== e.st || pend_any !== e.pd || sb_err !== e.er) begin
          n_bad++;
          $display("FAIL %s: got A=%h B=%h stall=%b pend=%b err=%b, want A=%h B=%h stall=%b pend=%b err=%b",
                   e.nm, valA, valB, stall, pend_any, sb_err, e.a, e.b, e.st, e.pd, e.er);
        end
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic mid,
                      input logic [3:0] sa, sb, de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm,
                      input logic [3:0] ce, cm, input logic cv,
                      input logic [63:0] ea, eb, input logic est, epd, eer);
    @(posedge clk);
    #1;
    rst = r; srcA = sa; srcB = sb; dstE = de; valE = ve; dstM = dm; valM = vm;
    claimE = ce; claimM = cm; claim_v = cv;
    q.push_back('{nm, ea, eb, est, epd, eer});
    chk = 1;
    if (mid) begin
      #2;
      rst = 1;
    end
  endtask

  initial begin
    //   name            rst mid sA sB dE  vE     dM  vM     cE cM cv  expA   expB st pd er
    step("rst_vals",     1, 0,  3, 14, N, 0,     N, 0,     N, N, 0,  3,     14,  0, 0, 0);
    step("rst_id15",     1, 0,  N, 0,  N, 0,     N, 0,     N, N, 0,  0,     0,   0, 0, 0);
    step("dual_wr_byp",  0, 0,  2, 1,  2, 'hAA,  2, 'hBB,  N, N, 0,  'hBB,  1,   0, 0, 0);
    step("dual_wr_st",   0, 0,  2, 15, N, 0,     N, 0,     N, N, 0,  'hBB,  0,   0, 0, 0);
    step("claim5",       0, 0,  5, 0,  N, 0,     N, 0,     5, N, 1,  5,     0,   0, 0, 0);
    step("stall5",       0, 0,  5, 0,  N, 0,     N, 0,     N, N, 0,  5,     0,   1, 1, 0);
    step("fwd5",         0, 0,  5, 0,  5, 'h77,  N, 0,     N, N, 0,  'h77,  0,   0, 1, 0);
    step("clear5",       0, 0,  5, 0,  N, 0,     N, 0,     N, N, 0,  'h77,  0,   0, 0, 0);
    step("claim4_a",     0, 0,  0, 0,  N, 0,     N, 0,     4, N, 1,  0,     0,   0, 0, 0);
    step("claim4_b",     0, 0,  0, 0,  N, 0,     N, 0,     N, 4, 1,  0,     0,   0, 1, 0);
    step("fwd4_cnt2",    0, 0,  4, 0,  4, 'h44,  N, 0,     N, N, 0,  'h44,  0,   0, 1, 0);
    step("restall4",     0, 0,  4, 0,  N, 0,     N, 0,     N, N, 0,  'h44,  0,   1, 1, 0);
    step("fwd4_m",       0, 0,  0, 4,  N, 0,     4, 'h45,  N, N, 0,  0,     'h45,0, 1, 0);
    step("clear4",       0, 0,  4, 4,  N, 0,     N, 0,     N, N, 0,  'h45,  'h45,0, 0, 0);
    step("claim6_both",  0, 0,  0, 0,  N, 0,     N, 0,     6, 6, 1,  0,     0,   0, 0, 0);
    step("claim6_2",     0, 0,  0, 0,  N, 0,     N, 0,     6, N, 1,  0,     0,   0, 1, 0);
    step("claim6_3",     0, 0,  0, 0,  N, 0,     N, 0,     6, N, 1,  0,     0,   0, 1, 0);
    step("claim6_ovf",   0, 0,  0, 0,  N, 0,     N, 0,     6, N, 1,  0,     0,   0, 1, 0);
    step("err_sticky",   0, 0,  6, 0,  N, 0,     N, 0,     N, N, 0,  6,     0,   1, 1, 1);
    step("fwd6_sat",     0, 0,  6, 0,  6, 'h66,  N, 0,     N, N, 0,  'h66,  0,   0, 1, 1);
    step("claim_ign",    0, 0,  6, 0,  N, 0,     N, 0,     5, N, 1,  'h66,  0,   1, 1, 1);
    step("ign_check",    0, 0,  5, 0,  N, 0,     N, 0,     N, N, 0,  'h77,  0,   0, 1, 1);
    step("claim5_r",     0, 0,  0, 0,  N, 0,     N, 0,     5, N, 1,  0,     0,   0, 1, 1);
    step("async_rst",    0, 1,  5, 6,  5, 'h99,  N, 0,     N, N, 0,  5,     6,   0, 0, 0);
    step("post_rst",     0, 0,  5, 6,  N, 0,     N, 0,     N, N, 0,  5,     6,   0, 0, 0);
    step("post_rst_r2",  0, 0,  2, 4,  N, 0,     N, 0,     N, N, 0,  2,     4,   0, 0, 0);
    @(posedge clk);
    #1;
    chk = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
